// File: rtl/lfsr_5_pkg.sv
// Shared types and defaults for the 5-bit LFSR stream checker.
package lfsr_5_pkg;

    typedef enum logic [1:0] {SYNC, VERIFY, LOCKED} chk_state_t;

    localparam int WIDTH_5 = 5;
    localparam logic [WIDTH_5-1:0] TAPS_5 = 5'b10100;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {CNT_W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/lfsr_5_seq_checker.sv
// Self-synchronising checker for a Fibonacci LFSR bitstream: predicts each bit from
// the last WIDTH received bits, tracks lock, and counts mispredictions while locked.
module lfsr_5_seq_checker
    import lfsr_5_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_5,
    parameter logic [WIDTH-1:0] TAPS       = TAPS_5,
    parameter int               LOCK_CNT   = 8,
    parameter int               ERR_THRESH = 3,
    parameter int               CNT_W      = 16
) (
    input  logic             clkTop,
    input  logic             rstTop,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic             lost_lock,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W = cnt_bits(WIDTH);
    localparam int RUN_W  = cnt_bits((LOCK_CNT > ERR_THRESH) ? LOCK_CNT : ERR_THRESH);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [RUN_W-1:0]  LOCK_RUN  = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  ERR_RUN   = RUN_W'(ERR_THRESH);

    chk_state_t         state_reg, state_next;
    logic [WIDTH-1:0]   hist_reg, hist_next, hist_shift;
    logic [FILL_W-1:0]  fill_reg, fill_next, fill_inc;
    logic [RUN_W-1:0]   run_reg, run_next, run_inc;
    logic               bit_err_reg, bit_err_next;
    logic               lost_lock_reg, lost_lock_next;
    logic               predicted, mismatch;
    logic [1:0]         cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_q;

    // Prediction uses the history as it stood before the incoming bit is shifted in.
    assign predicted  = ^(hist_reg & TAPS);
    assign mismatch   = bit_in ^ predicted;
    assign hist_shift = {hist_reg[WIDTH-2:0], bit_in};
    assign fill_inc   = (fill_reg < FILL_FULL) ? fill_reg + 1'b1 : FILL_FULL;
    assign run_inc    = run_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        fill_next      = fill_reg;
        run_next       = run_reg;
        bit_err_next   = 1'b0;
        lost_lock_next = 1'b0;
        cnt_inc        = '0;
        if (bit_valid) begin
            hist_next = hist_shift;
            unique case (state_reg)
                SYNC: begin
                    fill_next = fill_inc;
                    // An all-zero history is the LFSR lock-up state and can never verify.
                    if ((fill_inc == FILL_FULL) && (hist_shift != '0)) begin
                        state_next = VERIFY;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_next = SYNC;
                        fill_next  = FILL_FULL;
                        run_next   = '0;
                    end else if (run_inc == LOCK_RUN) begin
                        state_next = LOCKED;
                        run_next   = '0;
                    end else begin
                        run_next = run_inc;
                    end
                end
                LOCKED: begin
                    cnt_inc[1] = 1'b1;
                    if (mismatch) begin
                        bit_err_next = 1'b1;
                        cnt_inc[0]   = 1'b1;
                        if (run_inc == ERR_RUN) begin
                            state_next     = SYNC;
                            fill_next      = '0;
                            run_next       = '0;
                            lost_lock_next = 1'b1;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge clkTop) begin
        if (rstTop) begin
            state_reg     <= SYNC;
            hist_reg      <= '0;
            fill_reg      <= '0;
            run_reg       <= '0;
            bit_err_reg   <= 1'b0;
            lost_lock_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_reg      <= fill_next;
            run_reg       <= run_next;
            bit_err_reg   <= bit_err_next;
            lost_lock_reg <= lost_lock_next;
        end
    end

    // Index 0 counts bit errors, index 1 counts bits checked while locked.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk (clkTop),
                .srst(rstTop),
                .inc (cnt_inc[gi]),
                .clr (clr_cnt),
                .q   (cnt_q[gi])
            );
        end
    endgenerate

    assign locked    = (state_reg == LOCKED);
    assign bit_err   = bit_err_reg;
    assign lost_lock = lost_lock_reg;
    assign err_count = cnt_q[0];
    assign bit_count = cnt_q[1];

endmodule
